// File: rtl/xgmii_frame_switch.sv
`default_nettype none
// ============================================================================
// Module      : xgmii_frame_switch
// Description : NxN XGMII frame switch with start-of-frame routing, per-output
//               frame-granular round-robin arbitration and whole-frame drop.
//               Optional per-input drop counters: XGMII_SWITCH_DROP_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module xgmii_frame_switch #(
   parameter int NUM_PORTS = 2,
   parameter int SEL_W     = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1,
   parameter int CNT_W     = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [8*NUM_PORTS-1:0]       in_xgmii_ctrl,
   input  logic [64*NUM_PORTS-1:0]      in_xgmii_data,
   input  logic [SEL_W*NUM_PORTS-1:0]   route_sel,
   output logic [8*NUM_PORTS-1:0]       out_xgmii_ctrl,
   output logic [64*NUM_PORTS-1:0]      out_xgmii_data,
   output logic [CNT_W*NUM_PORTS-1:0]   drop_count
);

   localparam logic [7:0]  c_idle_ctrl = 8'hFF;
   localparam logic [63:0] c_idle_data = 64'h0707070707070707;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t               r_state      [NUM_PORTS];
   state_t               w_state_nxt  [NUM_PORTS];
   logic [SEL_W-1:0]     r_dest       [NUM_PORTS];
   logic [SEL_W-1:0]     w_dest_nxt   [NUM_PORTS];
   logic [SEL_W-1:0]     r_rr_ptr     [NUM_PORTS];
   logic [SEL_W-1:0]     w_rr_ptr_nxt [NUM_PORTS];
   logic [SEL_W-1:0]     w_route      [NUM_PORTS];
   logic [SEL_W-1:0]     w_grant_idx  [NUM_PORTS];
   logic [SEL_W-1:0]     w_active_dest[NUM_PORTS];
   logic [NUM_PORTS-1:0] w_sof;
   logic [NUM_PORTS-1:0] w_eof;
   logic [NUM_PORTS-1:0] w_busy;
   logic [NUM_PORTS-1:0] w_grant_vld;
   logic [NUM_PORTS-1:0] w_won;
   logic [NUM_PORTS-1:0] w_active;
   logic [8*NUM_PORTS-1:0]  w_out_ctrl;
   logic [64*NUM_PORTS-1:0] w_out_data;

   // Control symbol detection; start is recognised on lane 0 only
   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_det
      logic [7:0]  w_c;
      logic [63:0] w_d;
      logic [7:0]  w_eof_lane;
      assign w_c        = in_xgmii_ctrl[8*i +: 8];
      assign w_d        = in_xgmii_data[64*i +: 64];
      assign w_sof[i]   = w_c[0] && (w_d[7:0] == 8'hFB);
      assign w_route[i] = route_sel[SEL_W*i +: SEL_W];
      for (genvar l = 0; l < 8; l++) begin : g_lane
         assign w_eof_lane[l] = w_c[l] && (w_d[8*l +: 8] == 8'hFD);
      end
      assign w_eof[i] = |w_eof_lane;
   end

   // An output stays owned through the cycle its owner's EOF is accepted
   always_comb begin
      w_busy = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_state[i] == ST_FWD && r_dest[i] == SEL_W'(o)) begin
               w_busy[o] = 1'b1;
            end
         end
      end
   end

   always_comb begin : p_arb
      int idx;
      idx = 0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         w_grant_vld[o]  = 1'b0;
         w_grant_idx[o]  = '0;
         w_rr_ptr_nxt[o] = r_rr_ptr[o];
         for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(r_rr_ptr[o]) + k;
            if (idx >= NUM_PORTS) begin
               idx = idx - NUM_PORTS;
            end
            if (!w_busy[o] && !w_grant_vld[o] && r_state[idx] == ST_IDLE &&
                w_sof[idx] && w_route[idx] == SEL_W'(o)) begin
               w_grant_vld[o]  = 1'b1;
               w_grant_idx[o]  = SEL_W'(idx);
               w_rr_ptr_nxt[o] = (idx == NUM_PORTS - 1) ? '0 : SEL_W'(idx + 1);
            end
         end
      end
   end

   always_comb begin
      w_won = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         if (w_grant_vld[o]) begin
            w_won[w_grant_idx[o]] = 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_state_nxt[i]   = r_state[i];
         w_dest_nxt[i]    = r_dest[i];
         w_active[i]      = 1'b0;
         w_active_dest[i] = r_dest[i];
         case (r_state[i])
            ST_IDLE: begin
               if (w_sof[i]) begin
                  if (w_won[i]) begin
                     w_active[i]      = 1'b1;
                     w_active_dest[i] = w_route[i];
                     w_dest_nxt[i]    = w_route[i];
                     w_state_nxt[i]   = w_eof[i] ? ST_IDLE : ST_FWD;
                  end else begin
                     w_state_nxt[i]   = w_eof[i] ? ST_IDLE : ST_DROP;
                  end
               end
            end
            ST_FWD: begin
               w_active[i] = 1'b1;
               if (w_eof[i]) begin
                  w_state_nxt[i] = ST_IDLE;
               end
            end
            ST_DROP: begin
               if (w_eof[i]) begin
                  w_state_nxt[i] = ST_IDLE;
               end
            end
            default: w_state_nxt[i] = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_out_ctrl = {NUM_PORTS{c_idle_ctrl}};
      w_out_data = {NUM_PORTS{c_idle_data}};
      for (int o = 0; o < NUM_PORTS; o++) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_active[i] && w_active_dest[i] == SEL_W'(o)) begin
               w_out_ctrl[8*o +: 8]   = in_xgmii_ctrl[8*i +: 8];
               w_out_data[64*o +: 64] = in_xgmii_data[64*i +: 64];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            r_state[i]  <= ST_IDLE;
            r_dest[i]   <= '0;
            r_rr_ptr[i] <= '0;
         end
         out_xgmii_ctrl <= {NUM_PORTS{c_idle_ctrl}};
         out_xgmii_data <= {NUM_PORTS{c_idle_data}};
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            r_state[i]  <= w_state_nxt[i];
            r_dest[i]   <= w_dest_nxt[i];
            r_rr_ptr[i] <= w_rr_ptr_nxt[i];
         end
         out_xgmii_ctrl <= w_out_ctrl;
         out_xgmii_data <= w_out_data;
      end
   end

`ifdef XGMII_SWITCH_DROP_CNT_EN
   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cnt
      logic             w_drop;
      logic [CNT_W-1:0] r_cnt;
      assign w_drop = (r_state[i] == ST_IDLE) && w_sof[i] && !w_won[i];
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_cnt <= '0;
         end else if (w_drop && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
      assign drop_count[CNT_W*i +: CNT_W] = r_cnt;
   end
`else
   assign drop_count = '0;
`endif

endmodule
`default_nettype wire

// File: doc/xgmii_frame_switch.md
# xgmii_frame_switch

Parametrised N×N XGMII frame switch for the eth/PCIe datapath. It generalises the fixed point-to-point XGMII crossbar into `NUM_PORTS` inputs and `NUM_PORTS` outputs. Each input frame is steered by a per-input route select that is sampled only at start-of-frame. Contention for an output is resolved per output by a frame-granular round-robin arbiter, and frames that lose arbitration are dropped whole. All outputs are registered, and idle outputs carry XGMII idle.

## Interface
Parameters:
- `NUM_PORTS`, 2: number of input ports and number of output ports (2..8).
- `SEL_W`, `$clog2(NUM_PORTS)` (minimum 1): width of one route select.
- `CNT_W`, 16: width of each drop counter.

Ports:
- `clk`, input, 1: single clock for all logic.
- `reset`, input, 1: reset, asynchronous and active-low.
- `in_xgmii_ctrl`, input, 8·NUM_PORTS: per-input ctrl lanes; port i occupies bits [8i+7:8i].
- `in_xgmii_data`, input, 64·NUM_PORTS: per-input data; port i occupies bits [64i+63:64i].
- `route_sel`, input, SEL_W·NUM_PORTS: destination output for each input; sampled at start-of-frame only.
- `out_xgmii_ctrl`, output, 8·NUM_PORTS: per-output ctrl lanes.
- `out_xgmii_data`, output, 64·NUM_PORTS: per-output data.
- `drop_count`, output, CNT_W·NUM_PORTS: per-input count of dropped frames (see Configuration).

## Operation
Symbol detection:
- Start-of-frame (SOF): lane 0 has ctrl=1 and data=0xFB. A start on lane 4 is not recognised and is forwarded as data.
- End-of-frame (EOF): any lane has ctrl=1 and data=0xFD.

Per-input state machine, with states IDLE, FWD(o) and DROP:
- IDLE + SOF: read `route_sel[i]` to get o, then request output o.
  - If granted: go to FWD(o).
  - If not granted: go to DROP and increment `drop_count[i]`.
  - If EOF is in the same word: the frame is forwarded (or dropped) and the input returns to IDLE.
- FWD(o): forward each word to output o. On EOF, return to IDLE. A SOF seen in FWD is forwarded as data; the input is not re-routed.
- DROP: discard words. On EOF, return to IDLE.
- Route changes during a frame have no effect on that frame.

Per-output arbiter:
- Output o is free when it has no owner.
- Among inputs in IDLE that present SOF with route o in the same cycle, the grant goes to the first index at or after `rr_ptr[o]`, searching cyclically.
- On a grant, `rr_ptr[o]` becomes winner+1, modulo NUM_PORTS.
- The owner is released in the cycle its EOF word is accepted. A SOF from another input to o in that same cycle is dropped, because the output is still busy.
- An output with no owner emits idle: ctrl=0xFF and data=0x0707070707070707.

## Timing
- Latency is 1 cycle: an input word accepted at cycle T appears on its output at T+1.
- There are no bubbles and no backpressure.
- Grant and forwarding of the SOF word happen in the same cycle T.

Reset (asynchronous assert, synchronous deassert by the integrator):
- All inputs go to IDLE and all outputs are free.
- `rr_ptr` = 0.
- All outputs are idle: ctrl=0xFF, data=0x07 in every lane.
- `drop_count` = 0.

Reset mid-frame:
- Outputs go to idle immediately. The truncated frame is not terminated.
- After release, each input ignores words until its next SOF.

Counter behaviour:
- `drop_count` saturates at 2^CNT_W−1 and never wraps.

## Configuration
Macro `XGMII_SWITCH_DROP_CNT_EN`:
- Defined: per-input saturating drop counters are implemented and driven on `drop_count`.
- Undefined: no counter registers are built and `drop_count` is tied to 0. Drop behaviour is otherwise identical.

## Test plan
- **Single-path forwarding.** NUM_PORTS=2, route_sel={1,0}. Send a 64-byte frame on input 0 (SOF word ctrl=0x01/data=0x…FB, EOF in lane 3) -> identical words on output 1 at T+1. Output 0 stays at idle 0xFF/0x07….
- **Contention.** Both inputs route to output 0 and SOF arrives on both in the same cycle with rr_ptr=0 -> input 0 forwarded, input 1 frame fully absent from output 0, `drop_count[1]`=1, and rr_ptr[0]=1. Repeat the same case -> input 1 wins and `drop_count[0]`=1.
- **Mid-frame route change.** Change route_sel[0] from 1 to 0 in the middle of a frame -> the whole frame still appears on output 1. The next frame appears on output 0.
- **Back-to-back frames.** Input 1 sends SOF to output 0 in the same cycle that input 0's EOF is accepted on output 0 -> input 1's frame is dropped and the counter increments. A SOF one cycle later -> granted.
- **Reset mid-frame.** Assert reset mid-frame -> outputs are idle on the next edge. Release reset with the input still mid-frame -> nothing is forwarded until the next SOF, which is then forwarded normally.
- **Counter saturation.** With CNT_W=4, force 20 drops -> `drop_count` holds at 15. With the macro undefined -> `drop_count` stays 0 throughout.
